operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL run on one clock and use a synchronous, active-high reset, with ports as listed below.
REQ-002 The block SHALL provide: clk  in  1  rising-edge clock.
REQ-003 The block SHALL provide: rst  in  1  synchronous active-high reset.
REQ-004 The block SHALL provide: in_valid  in  1  instruction present.
REQ-005 The block SHALL provide: in_ready  out  1  instruction accepted when in_valid && in_ready.
REQ-006 The block SHALL provide: in_ctrl  in  1  ALU op (0 = AND, 1 = OR).
REQ-007 The block SHALL provide: in_ra, in_rb, in_rd  in  2 each  source A, source B and destination register indices.
REQ-008 The block SHALL provide: out_valid  out  1  operands valid toward the ALU.
REQ-009 The block SHALL provide: out_ready  in  1  ALU stage consumes when out_valid && out_ready.
REQ-010 The block SHALL provide: a, b  out  4 each  operand values for the ALU.
REQ-011 The block SHALL provide: ctrl  out  1  registered in_ctrl.
REQ-012 The block SHALL provide: out_rd  out  2  registered in_rd.
REQ-013 The block SHALL provide: wb_en  in  1  write-back strobe from the ALU result path.
REQ-014 The block SHALL provide: wb_addr  in  2  write-back register index.
REQ-015 The block SHALL provide: wb_data  in  4  write-back value (ALU result).

Function
REQ-016 Register file SHALL be 4 entries x 4 bits; all entries are ordinary (entry 0 is not hardwired to zero).
REQ-017 On a clk edge with wb_en=1, regfile[wb_addr] SHALL take wb_data, independent of every other input.
REQ-018 Scoreboard SHALL hold one pending bit per register; a bit is set when an instruction with that in_rd is accepted, and cleared by wb_en to that wb_addr.
REQ-019 If a set and a clear hit the same register in the same cycle, set SHALL win.
REQ-020 hazard SHALL equal pending[in_ra] | pending[in_rb] | pending[in_rd], after the exception in REQ-031.
REQ-021 in_ready SHALL equal !hazard && (!out_valid || out_ready); it is combinational, and in_valid does not feed in_ready.
REQ-022 An accepted instruction SHALL appear on a, b, ctrl and out_rd with out_valid=1 exactly one cycle after acceptance.
REQ-023 While out_valid=1 and out_ready=0, a, b, ctrl, out_rd and out_valid SHALL hold stable.
REQ-024 When the output is consumed and nothing is accepted in the same cycle, out_valid SHALL go to 0 on the next edge.
REQ-025 Consume and accept in the same cycle SHALL give back-to-back issue, with no bubble.
REQ-026 Operand read SHALL sample the register file in the acceptance cycle, before that cycle's write; see REQ-031 for forwarding.
REQ-027 in_ra = in_rb SHALL be legal, with both operands reading the same value.
REQ-028 wb_en for a register that is not pending SHALL still write the register file and leave the scoreboard unchanged.

Reset
REQ-029 On rst=1 at a clk edge: out_valid=0, a=0, b=0, ctrl=0, out_rd=0, all pending bits=0, all register file entries=0.
REQ-030 rst SHALL take priority over wb_en and acceptance in the same cycle; an in-flight instruction is discarded, and in_ready is 1 in the first cycle after reset.

Configuration
REQ-031 With macro OPFETCH_BYPASS_EN defined, a same-cycle wb_en clear of a pending source/destination register SHALL remove that term from hazard, and a or b SHALL take wb_data when its index equals wb_addr.
REQ-032 Without OPFETCH_BYPASS_EN, hazard SHALL use the registered pending bits only, the instruction stalls until the cycle after write-back, and there is no forwarding mux.

Verification
REQ-033 Reset, then write-back r1=0xA and r2=0x6; issue ctrl=0, ra=1, rb=2, rd=3 -> next cycle out_valid=1, a=0xA, b=0x6, ctrl=0, out_rd=3.
REQ-034 Issue rd=3, then immediately ra=3; wb_en r3=0x2 two cycles later -> second instruction stalls (in_ready=0); with bypass it issues in the write-back cycle with a=0x2, without bypass it issues one cycle later with a=0x2.
REQ-035 Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; then raise out_ready with a new valid instruction -> back-to-back issue.
REQ-036 Same cycle: accept an instruction with rd=1 while wb_en clears r1 -> pending[1] remains 1, and a following read of r1 stalls.
REQ-037 Assert rst with out_valid=1 and pending bits set -> next cycle all outputs 0, scoreboard clear, register file 0, in_ready=1.
REQ-038 Random stream of 200 instructions with an in-order write-back model -> every a/b matches the reference register model, and no instruction issues while its source or destination is pending.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: 4x4 register file, per-register pending scoreboard, one output register toward the ALU.
// Optional macro OPFETCH_BYPASS_EN forwards same-cycle write-back into hazard check and operand read.
module operand_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_ctrl,
  input  logic [1:0] in_ra,
  input  logic [1:0] in_rb,
  input  logic [1:0] in_rd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       ctrl,
  output logic [1:0] out_rd,
  input  logic       wb_en,
  input  logic [1:0] wb_addr,
  input  logic [3:0] wb_data
);
  localparam int NREG = 4;

  typedef struct packed {
    logic       ctrl;
    logic [1:0] rd;
    logic [3:0] a;
    logic [3:0] b;
  } op_t;

  logic [3:0]      rf [NREG];
  logic [NREG-1:0] pending, pend_eff, wb_hit, set_hit;
  logic [3:0]      rd_a, rd_b;
  logic            hazard, accept;
  op_t             op_d, op_q;

  always_comb begin
    wb_hit = '0;
    if (wb_en) wb_hit[wb_addr] = 1'b1;
  end

`ifdef OPFETCH_BYPASS_EN
  // A write-back landing this cycle both releases the hazard and supplies the operand.
  assign pend_eff = pending & ~wb_hit;
  assign rd_a     = (wb_en && wb_addr == in_ra) ? wb_data : rf[in_ra];
  assign rd_b     = (wb_en && wb_addr == in_rb) ? wb_data : rf[in_rb];
`else
  assign pend_eff = pending;
  assign rd_a     = rf[in_ra];
  assign rd_b     = rf[in_rb];
`endif

  assign hazard   = pend_eff[in_ra] | pend_eff[in_rb] | pend_eff[in_rd];
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    set_hit = '0;
    if (accept) set_hit[in_rd] = 1'b1;
  end

  always_comb begin
    op_d      = '0;
    op_d.ctrl = in_ctrl;
    op_d.rd   = in_rd;
    op_d.a    = rd_a;
    op_d.b    = rd_b;
  end

  // Clear is applied before set so a same-cycle issue to the written register stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      op_q      <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      pending <= (pending & ~wb_hit) | set_hit;
      if (wb_en) rf[wb_addr] <= wb_data;
      if (accept) op_q <= op_d;
      out_valid <= accept | (out_valid & ~out_ready);
    end
  end

  assign a      = op_q.a;
  assign b      = op_q.b;
  assign ctrl   = op_q.ctrl;
  assign out_rd = op_q.rd;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: vector table, directed stall/hold sequences, random stream against a queue/array reference model.
module tb_operand_fetch;
`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk, rst, in_valid, in_ready, in_ctrl, out_valid, out_ready, ctrl, wb_en;
  logic [1:0] in_ra, in_rb, in_rd, out_rd, wb_addr;
  logic [3:0] a, b, wb_data;

  int tests = 0;
  int fails = 0;

  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .ctrl(ctrl), .out_rd(out_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    int r, iv, ic, ra, rb, rd, ordy, we, wa, wd;
    int cir, eir, eov, cd, ea, eb, ec, erd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int r, int iv, int ic, int ra, int rb, int rd, int ordy,
                              int we, int wa, int wd, int cir, int eir, int eov, int cd,
                              int ea, int eb, int ec, int erd);
    vec_t v;
    v.r = r; v.iv = iv; v.ic = ic; v.ra = ra; v.rb = rb; v.rd = rd; v.ordy = ordy;
    v.we = we; v.wa = wa; v.wd = wd; v.cir = cir; v.eir = eir; v.eov = eov; v.cd = cd;
    v.ea = ea; v.eb = eb; v.ec = ec; v.erd = erd;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic setin(int v, int c, int ra, int rb, int rd, int ordy, int we, int wa, int wd);
    in_valid  = (v != 0);
    in_ctrl   = (c != 0);
    in_ra     = 2'(ra);
    in_rb     = 2'(rb);
    in_rd     = 2'(rd);
    out_ready = (ordy != 0);
    wb_en     = (we != 0);
    wb_addr   = 2'(wa);
    wb_data   = 4'(wd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_out(string nm, int ov, int ea, int eb, int ec, int erd);
    chk({nm, "_ov"}, int'(out_valid), ov);
    chk({nm, "_a"}, int'(a), ea);
    chk({nm, "_b"}, int'(b), eb);
    chk({nm, "_ctrl"}, int'(ctrl), ec);
    chk({nm, "_rd"}, int'(out_rd), erd);
  endtask

  // reference model state for the random stream
  int mrf[4], mpend[4];
  int wbq[$];
  int mov, ma, mb, mc, mrd;

  initial begin
    rst = 1'b1;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // r, iv, ic, ra, rb, rd, ordy, we, wa, wd | cir, eir, eov, cd, a, b, ctrl, rd
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 10,  1, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 2, 6,   1, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, 2, 3, 1, 0, 0, 0,   1, 1, 1, 1, 10, 6, 0, 3));
    // accept rd=1 while r1 is written: r1 stays pending; ra=rb reads the same value
    tv.push_back(mk(0, 1, 1, 2, 2, 1, 1, 1, 1, 5,   1, 1, 1, 1, 6, 6, 1, 1));
    tv.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
    if (BYP) begin
      tv.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1, 1, 9, 1, 1, 1, 1, 9, 0, 1, 0));
      tv.push_back(mk(0, 1, 0, 2, 2, 2, 1, 0, 0, 0, 1, 1, 1, 1, 6, 6, 0, 2));
    end else begin
      tv.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 9, 0, 1, 0));
    end
    // reset beats a write-back and an in-flight instruction
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 2, 15,  1, 0, 0, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 2, 1, 3, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, 2, 3, 0, 0, 0, 0,   1, 1, 1, 1, 0, 0, 0, 3));
    tv.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 0, 3));

    foreach (tv[i]) begin
      rst = (tv[i].r != 0);
      setin(tv[i].iv, tv[i].ic, tv[i].ra, tv[i].rb, tv[i].rd, tv[i].ordy, tv[i].we, tv[i].wa, tv[i].wd);
      #1;
      if (tv[i].cir != 0) chk($sformatf("vec%0d_in_ready", i), int'(in_ready), tv[i].eir);
      tick();
      if (tv[i].cd != 0)
        chk_out($sformatf("vec%0d", i), tv[i].eov, tv[i].ea, tv[i].eb, tv[i].ec, tv[i].erd);
      else
        chk($sformatf("vec%0d_ov", i), int'(out_valid), tv[i].eov);
    end
    rst = 1'b0;

    // output hold under backpressure, then back-to-back issue
    do_reset();
    setin(0, 0, 0, 0, 0, 0, 1, 0, 3); tick();
    setin(0, 0, 0, 0, 0, 0, 1, 1, 12); tick();
    setin(1, 1, 0, 1, 2, 0, 0, 0, 0); #1;
    chk("hold_issue_ir", int'(in_ready), 1);
    tick();
    chk_out("hold_first", 1, 3, 12, 1, 2);
    for (int k = 0; k < 3; k++) begin
      setin(1, 0, 1, 0, 3, 0, 0, 0, 0); #1;
      chk($sformatf("hold%0d_ir", k), int'(in_ready), 0);
      tick();
      chk_out($sformatf("hold%0d", k), 1, 3, 12, 1, 2);
    end
    setin(1, 0, 1, 0, 3, 1, 0, 0, 0); #1;
    chk("b2b_ir", int'(in_ready), 1);
    tick();
    chk_out("b2b", 1, 12, 3, 0, 3);
    setin(0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    chk("drain_ov", int'(out_valid), 0);

    // RAW stall on a pending destination
    do_reset();
    setin(1, 0, 0, 0, 3, 1, 0, 0, 0); #1;
    chk("raw_i1_ir", int'(in_ready), 1);
    tick();
    setin(1, 0, 3, 0, 0, 1, 0, 0, 0); #1;
    chk("raw_stall_ir", int'(in_ready), 0);
    tick();
    chk("raw_stall_ov", int'(out_valid), 0);
    setin(1, 0, 3, 0, 0, 1, 1, 3, 2); #1;
    if (BYP) begin
      chk("raw_wb_ir", int'(in_ready), 1);
      tick();
      chk_out("raw_issue", 1, 2, 0, 0, 0);
    end else begin
      chk("raw_wb_ir", int'(in_ready), 0);
      tick();
      setin(1, 0, 3, 0, 0, 1, 0, 0, 0); #1;
      chk("raw_after_ir", int'(in_ready), 1);
      tick();
      chk_out("raw_issue", 1, 2, 0, 0, 0);
    end

    // random stream vs reference model
    do_reset();
    for (int k = 0; k < 4; k++) begin mrf[k] = 0; mpend[k] = 0; end
    wbq.delete();
    mov = 0; ma = 0; mb = 0; mc = 0; mrd = 0;
    begin
      int issued, cyc;
      issued = 0;
      cyc = 0;
      while (issued < 200 && cyc < 5000) begin
        int iv, ic, ra, rb, rd, ordy, we, wa, wd, popq, hz, eir, k;
        int p[4];
        iv = ($urandom % 4 != 0) ? 1 : 0;
        ic = int'($urandom % 2);
        ra = int'($urandom % 4);
        rb = int'($urandom % 4);
        rd = int'($urandom % 4);
        ordy = ($urandom % 4 != 0) ? 1 : 0;
        wd = int'($urandom % 16);
        we = 0; wa = 0; popq = 0;
        if (wbq.size() > 0 && $urandom % 3 == 0) begin
          we = 1; wa = wbq[0]; popq = 1;
        end else if ($urandom % 8 == 0) begin
          k = int'($urandom % 4);
          if (mpend[k] == 0) begin we = 1; wa = k; end
        end
        setin(iv, ic, ra, rb, rd, ordy, we, wa, wd);
        #1;
        for (int j = 0; j < 4; j++)
          p[j] = (mpend[j] != 0 && !(BYP && we != 0 && wa == j)) ? 1 : 0;
        hz = (p[ra] != 0 || p[rb] != 0 || p[rd] != 0) ? 1 : 0;
        eir = (hz == 0 && (mov == 0 || ordy != 0)) ? 1 : 0;
        chk("rand_in_ready", int'(in_ready), eir);
        if (iv != 0 && eir != 0) begin
          ma = (BYP && we != 0 && wa == ra) ? wd : mrf[ra];
          mb = (BYP && we != 0 && wa == rb) ? wd : mrf[rb];
          mc = ic; mrd = rd; mov = 1;
          issued++;
        end else if (ordy != 0) begin
          mov = 0;
        end
        if (we != 0) begin
          mrf[wa] = wd;
          mpend[wa] = 0;
          if (popq != 0) void'(wbq.pop_front());
        end
        if (iv != 0 && eir != 0) begin
          mpend[rd] = 1;
          wbq.push_back(rd);
        end
        tick();
        cyc++;
        chk("rand_ov", int'(out_valid), mov);
        if (mov != 0) begin
          chk("rand_a", int'(a), ma);
          chk("rand_b", int'(b), mb);
          chk("rand_ctrl", int'(ctrl), mc);
          chk("rand_rd", int'(out_rd), mrd);
        end
      end
      chk("rand_issued", issued, 200);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
